// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares one data-memory port between an instruction-side requester (port 0)
//   and a load/store requester (port 1). One access is in flight at a time.
//   A three-state FSM (IDLE -> BUSY -> RESP) grants a port, runs the memory
//   access with a wait-state timeout, then returns a one-cycle done strobe
//   with read data and an error qualifier.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0/1, we0/1, addr0/1,
//   wd0/1, dtype0/1            per-port request and its fields
//   gnt0/1                     combinational accept (IDLE only, one-hot)
//   done0/1                    one-cycle completion strobe (RESP)
//   rdata, err                 response data / error, held until next RESP
//   mem_valid, mem_A, mem_WE,
//   mem_WD, mem_dataType       memory request, driven while BUSY
//   mem_ready, mem_RD          memory completion and read data
//   busy                       high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wd0,
    input  logic [DATA_WIDTH-1:0] wd1,
    input  logic [1:0]            dtype0,
    input  logic [1:0]            dtype1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic                  mem_WE,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic [1:0]            mem_dataType,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_RD,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] DTYPE_ILLEGAL = 2'b11;
    // The counter holds 0 in the first BUSY cycle, so the last allowed BUSY
    // cycle is the one where it reads TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [1:0]            dtype_q, dtype_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [1:0] req_v;
    logic [1:0] gnt_v;
    logic [1:0] done_v;
    logic       win;
    logic       grant_fire;
    logic       illegal;
    logic       timed_out;

    assign req_v     = {req1, req0};
    assign illegal   = (dtype_q == DTYPE_ILLEGAL);
    assign timed_out = (cnt_q == CNT_LAST);

    // Round-robin: a lone requester wins; under contention the port that was
    // not served last wins.
    always_comb begin
        win = 1'b0;
        if (req_v == 2'b11) begin
            win = ~last_grant_q;
        end else begin
            win = req1;
        end
    end

    // rst_n gates the grant so no accept is signalled while reset is held.
    assign grant_fire = rst_n && (state_q == S_IDLE) && (|req_v);

    // Per-port grant and done decode.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_v[gi]  = grant_fire && (win == 1'(gi));
            assign done_v[gi] = (state_q == S_RESP) && (port_q == 1'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wd_q         <= '0;
            dtype_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            dtype_q      <= dtype_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req_v) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Illegal sizes never touch memory; mem_ready beats timeout.
                if (illegal || mem_ready || timed_out) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------------- datapath
    always_comb begin
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wd_d         = wd_q;
        dtype_d      = dtype_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req_v) begin
                    port_d  = win;
                    we_d    = win ? we1    : we0;
                    addr_d  = win ? addr1  : addr0;
                    wd_d    = win ? wd1    : wd0;
                    dtype_d = win ? dtype1 : dtype0;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (illegal) begin
                    err_d = 1'b1;
                end else if (mem_ready) begin
                    err_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_RD;
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_RESP: begin
                last_grant_d = port_q;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        gnt0         = gnt_v[0];
        gnt1         = gnt_v[1];
        done0        = done_v[0];
        done1        = done_v[1];
        busy         = (state_q != S_IDLE);
        mem_valid    = (state_q == S_BUSY) && !illegal;
        mem_WE       = (state_q == S_BUSY) && !illegal && we_q;
        mem_A        = addr_q;
        mem_WD       = wd_q;
        mem_dataType = dtype_q;
        rdata        = rdata_q;
        err          = err_q;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte address width to the shared data memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of BUSY cycles waiting for mem_ready (range 1..255).
REQ-004 SHALL have the following ports; one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  access request; port 0 is instruction side, port 1 is load/store side.
- we0, we1  in  1 each  write enable per port.
- addr0, addr1  in  ADDR_WIDTH each  byte address per port.
- wd0, wd1  in  DATA_WIDTH each  write data per port.
- dtype0, dtype1  in  2 each  access size: 00 word, 01 byte, 10 halfword, 11 illegal.
- gnt0, gnt1  out  1 each  request accepted this cycle.
- done0, done1  out  1 each  one-cycle completion strobe.
- rdata  out  DATA_WIDTH  read data, valid with done0/done1.
- err  out  1  error qualifier, valid with done0/done1.
- mem_valid  out  1  memory access active.
- mem_A  out  ADDR_WIDTH  memory address.
- mem_WE  out  1  memory write enable.
- mem_WD  out  DATA_WIDTH  memory write data.
- mem_dataType  out  2  memory access size.
- mem_ready  in  1  memory completed the access this cycle.
- mem_RD  in  DATA_WIDTH  memory read data, valid with mem_ready.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement the states IDLE, BUSY and RESP.
REQ-006 In IDLE with at least one req, the block SHALL select one port, assert its gnt combinationally, latch its we/addr/wd/dtype and the port ID on the clock edge, and move to BUSY.
REQ-007 Arbitration SHALL be round-robin: a lone requester wins; with both requesting, the port other than last_grant wins; last_grant resets to 1, so port 0 wins the first contention.
REQ-008 At most one gnt SHALL be high in any cycle, and gnt SHALL be low outside IDLE.
REQ-009 Requesters SHALL hold req and their fields stable until gnt; a req dropped before gnt SHALL have no effect.
REQ-010 In BUSY the block SHALL drive mem_valid=1 and mem_A/mem_WE/mem_WD/mem_dataType from the latched fields; otherwise mem_valid=0 and mem_WE=0.
REQ-011 In BUSY, when mem_ready=1, a read SHALL capture mem_RD into rdata, and both reads and writes SHALL go to RESP with err=0.
REQ-012 A cycle counter SHALL clear on entry to BUSY and count BUSY cycles; after TIMEOUT BUSY cycles without mem_ready, the block SHALL go to RESP with err=1 and rdata=0.
REQ-013 If mem_ready and timeout occur in the same cycle, mem_ready SHALL win (err=0).
REQ-014 A granted request with dtype=11 SHALL skip memory (mem_valid stays 0), go IDLE->BUSY->RESP with err=1, and leave rdata unchanged.
REQ-015 In RESP the block SHALL assert done for the latched port for exactly one cycle, update last_grant to that port, and return to IDLE.
REQ-016 Latency from the gnt edge to done SHALL be 2 cycles when mem_ready=1 in the first BUSY cycle, plus 1 cycle per extra wait cycle.
REQ-017 rdata and err SHALL hold their values until the next RESP.
REQ-018 A new grant SHALL NOT occur in the RESP cycle, so back-to-back transactions are spaced by at least 3 cycles.

Reset
REQ-019 When rst_n=0, the block SHALL asynchronously force: state=IDLE, last_grant=1, counter=0, all gnt/done/mem_valid/mem_WE/busy/err=0, rdata=0, and latched fields=0.
REQ-020 A reset during BUSY SHALL abort the access with no done, and mem_valid SHALL drop immediately.

Verification
REQ-021 Single read: req1, addr1=0x0010, we1=0; mem_ready=1 with mem_RD=0xDEADBEEF in the first BUSY cycle -> gnt1 at cycle 0, mem_A=0x0010 at cycle 1, done1 with rdata=0xDEADBEEF and err=0 at cycle 2.
REQ-022 Contention: req0 and req1 both held after reset -> grants in the order port 0, port 1, port 0; never two gnts in one cycle.
REQ-023 Wait states: write word wd0=0x12345678, addr0=0x0004; mem_ready arrives after 3 BUSY cycles -> mem_WE=1 for 3 cycles, done0 at cycle 4, err=0.
REQ-024 Timeout: TIMEOUT=15, mem_ready never asserted -> exactly 15 BUSY cycles, then done with err=1 and rdata=0; mem_ready arriving on the 15th BUSY cycle -> err=0.
REQ-025 Illegal dtype=11 read on port 1 -> mem_valid stays 0 throughout, done1 at cycle 2 with err=1.
REQ-026 Reset asserted in the second BUSY cycle -> mem_valid=0 and busy=0 immediately, no done, and port 0 wins the next contention.
